// File: rtl/nios_audio_ocimem_pkg.sv
// Shared types and jdo field positions for the debug-memory access engine.
package nios_audio_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } ocimem_state_t;

  localparam int JDO_GO_BIT    = 35;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_audio_cpu_ocimem_ctrl.sv
// Sysclk-side debug-memory engine: turns debug-slave strobes into single-word
// RAM reads/writes with an auto-incrementing address and tracks monitor status.
module nios_audio_cpu_ocimem_ctrl
  import nios_audio_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              cpu_ctl_write,
  input  logic [1:0]        cpu_ctl_writedata,
  output logic [31:0]       MonDReg,
  output logic              monitor_go,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              cmd_overrun
);

  ocimem_state_t     state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              any_strobe;
  logic              drop;
  logic              unused_jdo_bits;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

  // Outside IDLE every strobe is lost; in IDLE only the lower-priority losers are.
  always_comb begin
    drop = 1'b0;
    if (state != ST_IDLE)
      drop = any_strobe;
    else
      drop = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
           | (take_action_ocimem_a & take_no_action_ocimem_a);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      mem_address   <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      MonDReg       <= '0;
      monitor_go    <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cmd_overrun   <= 1'b0;
    end else begin
      // Monitor control applies in every state; a same-cycle CPU set overrides the clear.
      if (take_action_ocimem_a && jdo[JDO_GO_BIT]) begin
        monitor_go    <= 1'b1;
        monitor_ready <= 1'b0;
        monitor_error <= 1'b0;
        cmd_overrun   <= 1'b0;
      end
      if (cpu_ctl_write) begin
        if (cpu_ctl_writedata[0]) begin
          monitor_ready <= 1'b1;
          monitor_go    <= 1'b0;
        end
        if (cpu_ctl_writedata[1])
          monitor_error <= 1'b1;
      end
      if (drop)
        cmd_overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo_wdata;
            mem_address   <= mon_a_reg;
            mem_writedata <= jdo_wdata;
            mem_write     <= 1'b1;
            state         <= ST_ACCESS;
          end else if (take_action_ocimem_a) begin
            mon_a_reg <= jdo_addr;
            if (jdo[JDO_RD_BIT]) begin
              mem_address <= jdo_addr;
              mem_read    <= 1'b1;
              state       <= ST_ACCESS;
            end
          end else if (take_no_action_ocimem_a) begin
            mem_address <= mon_a_reg;
            mem_read    <= 1'b1;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!mem_waitrequest) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_write) begin
              mon_a_reg <= mon_a_reg + 1'b1;
              state     <= ST_IDLE;
            end else begin
              state <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          MonDReg   <= mem_readdata;
          mon_a_reg <= mon_a_reg + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
